// File: rtl/noc_link_monitor.sv
// Credit-based multi-lane NoC link stage: pipelines flits forward and credits backward,
// and monitors credit accounting, packet framing and traffic statistics per lane.
module noc_link_monitor #(
  parameter int NUM_LINKS    = 4,
  parameter int FLIT_WIDTH   = 64,
  parameter int DEST_WIDTH   = 4,
  parameter int NUM_PIPELINE = 1,
  parameter int CREDIT_DEPTH = 2,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                  clk_noc,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_in     [0:NUM_LINKS-1],
  input  logic [DEST_WIDTH-1:0] dest_in     [0:NUM_LINKS-1],
  input  logic [0:NUM_LINKS-1]  is_tail_in,
  input  logic [0:NUM_LINKS-1]  send_in,
  output logic [0:NUM_LINKS-1]  credit_out,
  output logic [FLIT_WIDTH-1:0] data_out    [0:NUM_LINKS-1],
  output logic [DEST_WIDTH-1:0] dest_out    [0:NUM_LINKS-1],
  output logic [0:NUM_LINKS-1]  is_tail_out,
  output logic [0:NUM_LINKS-1]  send_out,
  input  logic [0:NUM_LINKS-1]  credit_in,
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] flit_count  [0:NUM_LINKS-1],
  output logic [STAT_WIDTH-1:0] pkt_count   [0:NUM_LINKS-1],
  output logic [0:NUM_LINKS-1]  err_no_credit,
  output logic [0:NUM_LINKS-1]  err_credit_overflow,
  output logic [0:NUM_LINKS-1]  err_dest_change
);

  localparam int FWD_W = FLIT_WIDTH + DEST_WIDTH + 2;
  localparam int CNT_W = $clog2(CREDIT_DEPTH + 1);
  localparam logic [CNT_W-1:0]      OUTST_FULL = CNT_W'(CREDIT_DEPTH);
  localparam logic [CNT_W-1:0]      OUTST_ONE  = CNT_W'(1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX   = '1;
  localparam logic [STAT_WIDTH-1:0] STAT_ONE   = STAT_WIDTH'(1);

  // state     | meaning
  // ST_IDLE   | between packets; next flit is a head
  // ST_IN_PKT | head seen, waiting for tail; dest must match r_head_dest
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_IN_PKT = 1'b1;

  for (genvar g = 0; g < NUM_LINKS; g++) begin : g_lane
    logic [FWD_W-1:0] w_fwd_in;
    logic [FWD_W-1:0] w_fwd_out;
    logic             w_crd_out;

    assign w_fwd_in = {data_in[g], dest_in[g], is_tail_in[g], send_in[g]};

    if (NUM_PIPELINE == 0) begin : g_comb
      assign w_fwd_out = w_fwd_in;
      assign w_crd_out = credit_in[g];
    end else begin : g_pipe
      logic [FWD_W-1:0] r_fwd [0:NUM_PIPELINE-1];
      logic             r_crd [0:NUM_PIPELINE-1];

      always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NUM_PIPELINE; i++) begin
            r_fwd[i] <= '0;
            r_crd[i] <= 1'b0;
          end
        end else begin
          r_fwd[0] <= w_fwd_in;
          r_crd[0] <= credit_in[g];
          for (int i = 1; i < NUM_PIPELINE; i++) begin
            r_fwd[i] <= r_fwd[i-1];
            r_crd[i] <= r_crd[i-1];
          end
        end
      end

      assign w_fwd_out = r_fwd[NUM_PIPELINE-1];
      assign w_crd_out = r_crd[NUM_PIPELINE-1];
    end

    assign {data_out[g], dest_out[g], is_tail_out[g], send_out[g]} = w_fwd_out;
    assign credit_out[g] = w_crd_out;

    logic [CNT_W-1:0]      r_outst;
    logic                  r_state;
    logic [DEST_WIDTH-1:0] r_head_dest;
    logic [STAT_WIDTH-1:0] r_flit_cnt;
    logic [STAT_WIDTH-1:0] r_pkt_cnt;
    logic                  r_err_nc;
    logic                  r_err_ov;
    logic                  r_err_dc;
    logic                  w_send;
    logic                  w_tail;
    logic                  w_no_credit;
    logic                  w_overflow;
    logic                  w_dest_chg;

    // Outstanding count watches the credit as seen by upstream, i.e. after the return pipeline.
    assign w_send      = send_in[g];
    assign w_tail      = is_tail_in[g];
    assign w_no_credit = w_send & ~w_crd_out & (r_outst == OUTST_FULL);
    assign w_overflow  = ~w_send & w_crd_out & (r_outst == '0);
    assign w_dest_chg  = w_send & (r_state == ST_IN_PKT) & (dest_in[g] != r_head_dest);

    always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
        r_outst     <= '0;
        r_state     <= ST_IDLE;
        r_head_dest <= '0;
        r_flit_cnt  <= '0;
        r_pkt_cnt   <= '0;
        r_err_nc    <= 1'b0;
        r_err_ov    <= 1'b0;
        r_err_dc    <= 1'b0;
      end else begin
        if (w_send && !w_crd_out && !w_no_credit) begin
          r_outst <= r_outst + OUTST_ONE;
        end else if (!w_send && w_crd_out && !w_overflow) begin
          r_outst <= r_outst - OUTST_ONE;
        end

        if (w_send) begin
          if (r_state == ST_IDLE) begin
            if (!w_tail) begin
              r_head_dest <= dest_in[g];
              r_state     <= ST_IN_PKT;
            end
          end else if (w_tail) begin
            r_state <= ST_IDLE;
          end
        end

        if (stat_clear) begin
          r_flit_cnt <= '0;
          r_pkt_cnt  <= '0;
          r_err_nc   <= 1'b0;
          r_err_ov   <= 1'b0;
          r_err_dc   <= 1'b0;
        end else begin
          if (w_send && (r_flit_cnt != STAT_MAX)) r_flit_cnt <= r_flit_cnt + STAT_ONE;
          if (w_send && w_tail && (r_pkt_cnt != STAT_MAX)) r_pkt_cnt <= r_pkt_cnt + STAT_ONE;
          if (w_no_credit) r_err_nc <= 1'b1;
          if (w_overflow)  r_err_ov <= 1'b1;
          if (w_dest_chg)  r_err_dc <= 1'b1;
        end
      end
    end

    assign flit_count[g]          = r_flit_cnt;
    assign pkt_count[g]           = r_pkt_cnt;
    assign err_no_credit[g]       = r_err_nc;
    assign err_credit_overflow[g] = r_err_ov;
    assign err_dest_change[g]     = r_err_dc;
  end

endmodule

// File: tb/tb_noc_link_monitor.sv
// Directed bench for noc_link_monitor with 3 pipeline stages, 2 credits and 4-bit statistics.
module tb_noc_link_monitor;
  localparam int NL = 4;
  localparam int FW = 16;
  localparam int DW = 4;
  localparam int NP = 3;
  localparam int CD = 2;
  localparam int SW = 4;

  logic          clk_noc = 1'b0;
  logic          rst_n;
  logic [FW-1:0] data_in  [0:NL-1];
  logic [DW-1:0] dest_in  [0:NL-1];
  logic [0:NL-1] is_tail_in, send_in, credit_in;
  logic [0:NL-1] credit_out, is_tail_out, send_out;
  logic [FW-1:0] data_out [0:NL-1];
  logic [DW-1:0] dest_out [0:NL-1];
  logic          stat_clear;
  logic [SW-1:0] flit_count [0:NL-1];
  logic [SW-1:0] pkt_count  [0:NL-1];
  logic [0:NL-1] err_no_credit, err_credit_overflow, err_dest_change;

  int n_cmp = 0;
  int n_mis = 0;

  noc_link_monitor #(
    .NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .NUM_PIPELINE(NP), .CREDIT_DEPTH(CD), .STAT_WIDTH(SW)
  ) dut (
    .clk_noc(clk_noc), .rst_n(rst_n),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out), .send_out(send_out),
    .credit_in(credit_in), .stat_clear(stat_clear),
    .flit_count(flit_count), .pkt_count(pkt_count),
    .err_no_credit(err_no_credit), .err_credit_overflow(err_credit_overflow),
    .err_dest_change(err_dest_change)
  );

  always #5 clk_noc = ~clk_noc;

  task automatic step();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("%s_send%0d", tag, l), send_out[l], 0);
      chk($sformatf("%s_tail%0d", tag, l), is_tail_out[l], 0);
      chk($sformatf("%s_data%0d", tag, l), data_out[l], 0);
      chk($sformatf("%s_dest%0d", tag, l), dest_out[l], 0);
      chk($sformatf("%s_crd%0d", tag, l), credit_out[l], 0);
      chk($sformatf("%s_fcnt%0d", tag, l), flit_count[l], 0);
      chk($sformatf("%s_pcnt%0d", tag, l), pkt_count[l], 0);
      chk($sformatf("%s_errs%0d", tag, l),
          {err_no_credit[l], err_credit_overflow[l], err_dest_change[l]}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    stat_clear = 1'b0;
    send_in = '0; is_tail_in = '0; credit_in = '0;
    for (int l = 0; l < NL; l++) begin
      data_in[l] = '0;
      dest_in[l] = '0;
    end
    repeat (3) step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(); step();

    // Credit returned with nothing outstanding on lane 0
    credit_in[0] = 1'b1;
    step(); credit_in[0] = 1'b0;
    step();
    chk("ovf_crd_early", credit_out[0], 0);
    step();
    chk("ovf_crd_out", credit_out[0], 1);
    chk("ovf_flag_early", err_credit_overflow[0], 0);
    step();
    chk("ovf_flag", err_credit_overflow[0], 1);
    chk("ovf_other", {err_credit_overflow[1], err_credit_overflow[2], err_credit_overflow[3]}, 0);

    // Three-flit packet on lane 2, third flit exceeds the two credits
    send_in[2] = 1'b1; dest_in[2] = 4'h5; data_in[2] = 16'h00A0; is_tail_in[2] = 1'b0;
    step(); data_in[2] = 16'h00A1;
    chk("lat_early1", send_out[2], 0);
    step(); data_in[2] = 16'h00A2; is_tail_in[2] = 1'b1;
    chk("lat_early2", send_out[2], 0);
    step(); send_in[2] = 1'b0; is_tail_in[2] = 1'b0; data_in[2] = '0; dest_in[2] = '0;
    chk("lat_f0", {send_out[2], is_tail_out[2], dest_out[2], data_out[2]}, {1'b1, 1'b0, 4'h5, 16'h00A0});
    chk("lat_fcnt", flit_count[2], 3);
    chk("lat_pcnt", pkt_count[2], 1);
    chk("lat_nocrd", err_no_credit[2], 1);
    step();
    chk("lat_f1", {send_out[2], is_tail_out[2], dest_out[2], data_out[2]}, {1'b1, 1'b0, 4'h5, 16'h00A1});
    step();
    chk("lat_f2", {send_out[2], is_tail_out[2], dest_out[2], data_out[2]}, {1'b1, 1'b1, 4'h5, 16'h00A2});
    chk("lat_destchg", err_dest_change[2], 0);
    step();
    chk("lat_idle", send_out[2], 0);

    stat_clear = 1'b1;
    step(); stat_clear = 1'b0;
    chk("clr_ovf0", err_credit_overflow[0], 0);
    chk("clr_nc2", err_no_credit[2], 0);
    chk("clr_fcnt2", flit_count[2], 0);

    // Credit loop on lane 1
    send_in[1] = 1'b1; is_tail_in[1] = 1'b1; dest_in[1] = 4'h1; data_in[1] = 16'h0011;
    step();
    step(); send_in[1] = 1'b0; credit_in[1] = 1'b1;
    step(); credit_in[1] = 1'b0;
    step();
    step();
    chk("loop_crd_out", credit_out[1], 1);
    send_in[1] = 1'b1;
    step(); send_in[1] = 1'b0;
    chk("loop_no_nc", err_no_credit[1], 0);
    chk("loop_no_ovf", err_credit_overflow[1], 0);
    chk("loop_fcnt", flit_count[1], 3);
    credit_in[1] = 1'b1;
    step(); credit_in[1] = 1'b0; send_in[1] = 1'b1;
    step(); send_in[1] = 1'b0;
    chk("loop_nc", err_no_credit[1], 1);
    step();
    chk("loop_crd2", credit_out[1], 1);
    step();
    chk("loop_ovf_after", err_credit_overflow[1], 0);

    // Destination change inside a packet on lane 3
    send_in[3] = 1'b1; dest_in[3] = 4'h3; data_in[3] = 16'h0033; is_tail_in[3] = 1'b0;
    step(); dest_in[3] = 4'h7; data_in[3] = 16'h0077; is_tail_in[3] = 1'b1; credit_in[3] = 1'b1;
    step(); send_in[3] = 1'b0; is_tail_in[3] = 1'b0;
    chk("dc_flag", err_dest_change[3], 1);
    step(); credit_in[3] = 1'b0;
    chk("dc_head", {send_out[3], is_tail_out[3], dest_out[3], data_out[3]}, {1'b1, 1'b0, 4'h3, 16'h0033});
    stat_clear = 1'b1;
    step(); stat_clear = 1'b0;
    chk("dc_body", {send_out[3], is_tail_out[3], dest_out[3], data_out[3]}, {1'b1, 1'b1, 4'h7, 16'h0077});
    chk("dc_cleared", err_dest_change[3], 0);
    step();
    step(); send_in[3] = 1'b1; is_tail_in[3] = 1'b1; dest_in[3] = 4'h7; data_in[3] = 16'h007A;
    step(); send_in[3] = 1'b0; is_tail_in[3] = 1'b0;
    chk("dc_single_ok", err_dest_change[3], 0);
    chk("dc_single_pcnt", pkt_count[3], 1);
    chk("dc_single_nc", err_no_credit[3], 0);

    // Saturation on lane 0, credits returned alongside each send
    is_tail_in[0] = 1'b1; dest_in[0] = 4'h2; data_in[0] = 16'h0202;
    for (int i = 0; i < 20; i++) begin
      send_in[0] = 1'b1; credit_in[0] = 1'b1;
      step();
      chk($sformatf("sat_fcnt%0d", i), flit_count[0], (i + 1 > 15) ? 15 : i + 1);
      send_in[0] = 1'b0; credit_in[0] = 1'b0;
      step();
    end
    chk("sat_pcnt", pkt_count[0], 15);
    chk("sat_errs", {err_no_credit[0], err_credit_overflow[0]}, 0);
    send_in[0] = 1'b1; credit_in[0] = 1'b1; stat_clear = 1'b1;
    step(); send_in[0] = 1'b0; credit_in[0] = 1'b0; stat_clear = 1'b0;
    chk("clr_fcnt", flit_count[0], 0);
    chk("clr_pcnt", pkt_count[0], 0);
    step();
    send_in[0] = 1'b1; credit_in[0] = 1'b1;
    step(); send_in[0] = 1'b0; credit_in[0] = 1'b0;
    chk("post_clr_fcnt", flit_count[0], 1);
    chk("post_clr_pcnt", pkt_count[0], 1);

    // Async reset mid-packet on lane 1 with flits and a credit in flight
    step(); step(); step(); step();
    send_in[1] = 1'b1; dest_in[1] = 4'h4; data_in[1] = 16'h0041; is_tail_in[1] = 1'b0;
    step(); data_in[1] = 16'h0042;
    step(); data_in[1] = 16'h0043; credit_in[1] = 1'b1;
    step(); credit_in[1] = 1'b0;
    chk("ar_pre", {send_out[1], data_out[1]}, {1'b1, 16'h0041});
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async");
    send_in[1] = 1'b0;
    #2 rst_n = 1'b1;
    step();
    send_in[1] = 1'b1; dest_in[1] = 4'h9; data_in[1] = 16'h0091; is_tail_in[1] = 1'b0;
    step(); is_tail_in[1] = 1'b1;
    step(); send_in[1] = 1'b0; is_tail_in[1] = 1'b0;
    chk("ar_newhead", err_dest_change[1], 0);
    chk("ar_pcnt", pkt_count[1], 1);
    step(); step(); step();
    chk("ar_crd_dropped", err_credit_overflow[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/noc_link_monitor.md
# noc_link_monitor

Credit-based, multi-lane NoC link stage for the router-to-router ports of the router wrapper. Each lane inserts `NUM_PIPELINE` register stages forward (flit path) and backward (credit path), so routers can be placed far apart. Each lane also runs an inline protocol monitor:
- credit accounting against the downstream buffer depth;
- packet framing and destination checking;
- saturating flit and packet statistics.

It sits between a router's output port bundle and the neighbouring router's input port bundle. It replaces direct wiring.

## Interface
Parameters:
- `NUM_LINKS`, 4: number of independent lanes (router ports minus local).
- `FLIT_WIDTH`, 64: flit payload width.
- `DEST_WIDTH`, 4: destination field width.
- `NUM_PIPELINE`, 1: register stages per direction. Legal range 0..8; 0 means combinational pass-through.
- `CREDIT_DEPTH`, 2: downstream input buffer depth, equal to the router's `FLIT_BUFFER_DEPTH`. Legal range 1..64.
- `STAT_WIDTH`, 16: width of each statistics counter.

Ports:
- `clk_noc` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in [0:NUM_LINKS-1][FLIT_WIDTH]: upstream flit data.
- `dest_in` in [0:NUM_LINKS-1][DEST_WIDTH]: upstream flit destination.
- `is_tail_in` in [0:NUM_LINKS-1]: upstream tail marker.
- `send_in` in [0:NUM_LINKS-1]: upstream flit valid.
- `credit_out` out [0:NUM_LINKS-1]: credit returned to upstream.
- `data_out` out [0:NUM_LINKS-1][FLIT_WIDTH]: downstream flit data.
- `dest_out` out [0:NUM_LINKS-1][DEST_WIDTH]: downstream flit destination.
- `is_tail_out` out [0:NUM_LINKS-1]: downstream tail marker.
- `send_out` out [0:NUM_LINKS-1]: downstream flit valid.
- `credit_in` in [0:NUM_LINKS-1]: credit pulse from downstream.
- `stat_clear` in 1: synchronous clear of all counters and error flags.
- `flit_count` out [0:NUM_LINKS-1][STAT_WIDTH]: flits accepted per lane.
- `pkt_count` out [0:NUM_LINKS-1][STAT_WIDTH]: tails accepted per lane.
- `err_no_credit` out [0:NUM_LINKS-1]: sticky; a send occurred with zero credits.
- `err_credit_overflow` out [0:NUM_LINKS-1]: sticky; a credit was returned with nothing outstanding.
- `err_dest_change` out [0:NUM_LINKS-1]: sticky; the destination changed inside a packet.

## Operation
- **Forward path.** `{data, dest, is_tail, send}` pass through a chain of `NUM_PIPELINE` registers, with no stall and no backpressure.
- **Credit path.** `credit_in` passes through an independent chain of `NUM_PIPELINE` registers to `credit_out`. Every pulse is preserved one-for-one.
- **Outstanding counter (per lane).** Width is clog2(CREDIT_DEPTH+1). The counter observes `send_in` and `credit_out`; it is not the router's counter.
  - `send_in` only: +1.
  - `credit_out` only: −1.
  - Both in the same cycle: unchanged, and this is legal even when the counter is full.
- **Illegal events.** The counter holds its value in both cases.
  - `send_in` without `credit_out` while outstanding==CREDIT_DEPTH sets `err_no_credit`.
  - `credit_out` without `send_in` while outstanding==0 sets `err_credit_overflow`.
- **Framing FSM (per lane).** States are IDLE and IN_PKT. A `head_dest` register holds the destination of the current packet's head flit.
  - IDLE, `send_in` & !`is_tail_in`: capture `dest_in` into `head_dest`, go to IN_PKT.
  - IDLE, `send_in` & `is_tail_in`: single-flit packet, stay in IDLE.
  - IN_PKT, `send_in`: if `dest_in` != `head_dest`, set `err_dest_change`. If `is_tail_in`, return to IDLE.
  - The flit is always forwarded unchanged; the monitor never alters traffic.
- **Statistics.**
  - `flit_count` increments on each `send_in`.
  - `pkt_count` increments on each `send_in` & `is_tail_in`.
  - Both saturate at 2^STAT_WIDTH−1 and never wrap.
- **`stat_clear`.**
  - Zeroes `flit_count`, `pkt_count` and all error flags.
  - Does not touch the outstanding counter, the FSM state or the pipelines.
  - If an event occurs in the same cycle as `stat_clear`, the clear wins and the event is not counted.
- **Lanes.** All lanes are fully independent, with no shared state.

## Timing
- **Reset values.**
  - All pipeline registers are 0, so `send_out`, `credit_out`, `is_tail_out`, `data_out` and `dest_out` are 0.
  - Outstanding counter is 0; FSM is IDLE.
  - All counters and error flags are 0.
- **Reset mid-operation.** Asserting reset discards flits and credits held in the pipeline. System-level reset is global, so neighbouring routers reset together.
- **Latency.**
  - Flit: `send_in` at cycle t gives `send_out` at t+NUM_PIPELINE, with the same data, dest and tail.
  - Credit: `credit_in` at t gives `credit_out` at t+NUM_PIPELINE.
  - With NUM_PIPELINE=0, both paths are combinational.
- **Monitor outputs** are registered. A counter or flag updates in cycle t+1 for an event at t. A flag stays set until `stat_clear` or reset.
- **Throughput.** One flit and one credit per lane per cycle, in any cycle.

## Test plan
- **Latency, NUM_PIPELINE=3.**
  - Stimulus: lane 2 sends a 3-flit packet, dest 0x5, data 0xA0..0xA2, at cycles 10–12.
  - Required: `send_out[2]` high at cycles 13–15 with identical data, and tail at cycle 15.
  - Required: `flit_count[2]`=3 and `pkt_count[2]`=1.
- **Credit loop, CREDIT_DEPTH=2.**
  - Stimulus: 2 sends, then pulse `credit_in` once, wait NUM_PIPELINE cycles, then send again.
  - Required: no error flags. A 3rd send issued before the credit reaches `credit_out` sets `err_no_credit` on the next cycle.
- **Credit overflow.**
  - Stimulus: right after reset, pulse `credit_in[0]`.
  - Required: `err_credit_overflow[0]`=1 exactly NUM_PIPELINE+1 cycles later; other lanes stay 0.
- **Destination change.**
  - Stimulus: head flit dest 0x3 (not tail), body flit dest 0x7.
  - Required: `err_dest_change` set; both flits still forwarded unchanged.
  - Stimulus: a following single-flit packet with dest 0x7.
  - Required: no new error is raised by it.
- **Saturation and clear, STAT_WIDTH=4.**
  - Stimulus: 20 single-flit packets.
  - Required: `flit_count`=15 and `pkt_count`=15.
  - Stimulus: `stat_clear` in the same cycle as a send.
  - Required: both counters read 0 the next cycle.
- **Async reset.**
  - Stimulus: drop `rst_n` mid-packet with flits in flight.
  - Required: all outputs read 0 immediately, with no clock edge.
  - Stimulus: after release, send a body flit with a different dest.
  - Required: treated as a new head (FSM was IDLE), so no `err_dest_change`.
